mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port word memory between the cpu core (requester 0) and an auxiliary bus master (requester 1), e.g. a loader, DMA or display fetcher.
- Sits between the requesters and the memory's re/we/addr/rdata/wdata port.
- Round-robin arbitration with an optional bounded burst lock for the aux master.
- Tracks in-flight reads so returned data is steered, with a valid strobe, to the requester that issued the read.

---
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-requester memory arbiter with aux burst lock and read-return steering
module mem_arbiter #(
  parameter int AWIDTH   = 16,
  parameter int DWIDTH   = 16,
  parameter int RLAT     = 1,
  parameter int MAXBURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [AWIDTH-2:0] c_addr,
  input  logic [DWIDTH-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DWIDTH-1:0] c_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-2:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DWIDTH-1:0] a_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [AWIDTH-2:0] memaddr,
  output logic [DWIDTH-1:0] wmemdata,
  input  logic [DWIDTH-1:0] rmemdata
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t          state;
  logic            last_owner;
  logic [7:0]      bcnt;
  logic [RLAT-1:0] tag_v, tag_o;
  logic            a_win, c_win, g_we;
  // pick this cycle's winner and drive the memory port from it
  always_comb begin
    a_win    = ~rst & a_req & ((state == LOCKED) | ~c_req | ~last_owner);
    c_win    = ~rst & c_req & ~a_win & (state == IDLE);
    g_we     = a_win ? a_we : c_we;
    c_gnt    = c_win;
    a_gnt    = a_win;
    mem_re   = (a_win | c_win) & ~g_we;
    mem_we   = (a_win | c_win) & g_we;
    memaddr  = a_win ? a_addr : c_win ? c_addr : '0;
    wmemdata = a_win ? a_wdata : c_win ? c_wdata : '0;
    c_rdata  = rmemdata;
    a_rdata  = rmemdata;
  end
  // round-robin owner and aux burst lock; last grant of a burst is aux, so the cpu wins next
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      bcnt       <= '0;
    end else begin
      if (a_win | c_win) last_owner <= a_win;
      if (state == IDLE) begin
        if (a_win & a_lock & (MAXBURST > 1)) begin
          state <= LOCKED;
          bcnt  <= 8'd1;
        end
      end else if (!a_req) state <= IDLE;
      else begin
        bcnt <= bcnt + 8'd1;
        if (!a_lock || (bcnt + 8'd1 == 8'(MAXBURST))) state <= IDLE;
      end
    end
  end
  // read tags travel alongside the memory latency and are retimed onto rvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v    <= '0;
      tag_o    <= '0;
      c_rvalid <= 1'b0;
      a_rvalid <= 1'b0;
    end else begin
      tag_v[0] <= mem_re;
      tag_o[0] <= a_win;
      for (int i = 1; i < RLAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
      c_rvalid <= tag_v[RLAT-1] & ~tag_o[RLAT-1];
      a_rvalid <= tag_v[RLAT-1] & tag_o[RLAT-1];
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter at RLAT=1/MAXBURST=4 and RLAT=3/MAXBURST=3
module tb_mem_arbiter;
  typedef struct {bit v; bit own; logic [15:0] d;} rec_t;
  typedef struct {bit cr; bit ar; bit al; bit ec; bit ea;} vec_t;
  logic clk = 0, rst = 1;
  logic c_req = 0, c_we = 0, a_req = 0, a_we = 0, a_lock = 0;
  logic [14:0] c_addr = '0, a_addr = '0;
  logic [15:0] c_wdata = '0, a_wdata = '0;
  logic [1:0] c_gnt, a_gnt, c_rv, a_rv, mre, mwe;
  logic [15:0] c_rd [2], a_rd [2], wd [2], rmd [2];
  logic [14:0] ma [2];
  logic [15:0] mem [2][256];
  logic [15:0] d0;
  logic [15:0] d1 [3];
  logic [15:0] sh [2][256];
  rec_t ring [2][64];
  bit lo [2], lk [2];
  int cnt [2];
  int cyc = 0, checks = 0, failures = 0;
  bit men = 0;
  vec_t tbl [17];

  mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .RLAT(1), .MAXBURST(4)) u0 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt[0]), .c_rvalid(c_rv[0]), .c_rdata(c_rd[0]),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(a_gnt[0]), .a_rvalid(a_rv[0]), .a_rdata(a_rd[0]),
    .mem_re(mre[0]), .mem_we(mwe[0]), .memaddr(ma[0]), .wmemdata(wd[0]), .rmemdata(rmd[0]));

  mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .RLAT(3), .MAXBURST(3)) u1 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt[1]), .c_rvalid(c_rv[1]), .c_rdata(c_rd[1]),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(a_gnt[1]), .a_rvalid(a_rv[1]), .a_rdata(a_rd[1]),
    .mem_re(mre[1]), .mem_we(mwe[1]), .memaddr(ma[1]), .wmemdata(wd[1]), .rmemdata(rmd[1]));

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return (i == 16) ? 16'hBEEF : (16'(i * 311) ^ 16'hA5C3);
  endfunction

  // memories: one per DUT, read data appears RLAT edges after the sampling edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++)
      if (cyc == 0) for (int i = 0; i < 256; i++) mem[k][i] <= pat(i);
      else if (mwe[k]) mem[k][ma[k][7:0]] <= wd[k];
    d0 <= mem[0][ma[0][7:0]];
    d1[0] <= mem[1][ma[1][7:0]];
    d1[1] <= d1[0];
    d1[2] <= d1[1];
    rmd[0] <= d0;
    rmd[1] <= d1[2];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // reference model: expected returns are scheduled by cycle number in a ring
  task automatic model_step(input int k, input int lat, input int mb);
    rec_t e;
    logic ec, ea, ew;
    logic [7:0] idx;
    int s;
    s = cyc % 64;
    e = ring[k][s];
    ring[k][s].v = 0;
    chk($sformatf("m%0d_c_rvalid", k), c_rv[k], e.v && !e.own);
    chk($sformatf("m%0d_a_rvalid", k), a_rv[k], e.v && e.own);
    if (e.v) chk($sformatf("m%0d_rdata", k), e.own ? a_rd[k] : c_rd[k], e.d);
    if (rst) {ec, ea} = 2'b00;
    else if (lk[k]) {ec, ea} = {1'b0, a_req};
    else if (c_req && a_req) {ec, ea} = lo[k] ? 2'b10 : 2'b01;
    else {ec, ea} = {c_req, a_req};
    ew = ea ? a_we : c_we;
    chk($sformatf("m%0d_c_gnt", k), c_gnt[k], ec);
    chk($sformatf("m%0d_a_gnt", k), a_gnt[k], ea);
    chk($sformatf("m%0d_mem_re", k), mre[k], (ec || ea) && !ew);
    chk($sformatf("m%0d_mem_we", k), mwe[k], (ec || ea) && ew);
    chk($sformatf("m%0d_memaddr", k), ma[k], ea ? a_addr : ec ? c_addr : 15'd0);
    chk($sformatf("m%0d_wmemdata", k), wd[k], ea ? a_wdata : ec ? c_wdata : 16'd0);
    if (rst) begin
      for (int i = 0; i < 64; i++) ring[k][i].v = 0;
      lo[k] = 1;
      lk[k] = 0;
      cnt[k] = 0;
    end else begin
      if (ec || ea) begin
        idx = ea ? a_addr[7:0] : c_addr[7:0];
        if (ew) sh[k][idx] = ea ? a_wdata : c_wdata;
        else begin
          ring[k][(cyc + lat + 1) % 64].v = 1;
          ring[k][(cyc + lat + 1) % 64].own = ea;
          ring[k][(cyc + lat + 1) % 64].d = sh[k][idx];
        end
        lo[k] = ea;
      end
      if (!lk[k]) begin
        if (ea && a_lock && mb > 1) begin
          lk[k] = 1;
          cnt[k] = 1;
        end
      end else if (!ea) lk[k] = 0;
      else begin
        cnt[k]++;
        if (!a_lock || cnt[k] == mb) lk[k] = 0;
      end
    end
  endtask

  always @(negedge clk) if (men) begin
    model_step(0, 1, 4);
    model_step(1, 3, 3);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl = '{'{1,1,0,1,0}, '{1,1,0,0,1}, '{1,1,0,1,0}, '{1,1,1,0,1}, '{1,1,1,0,1},
            '{1,1,1,0,1}, '{1,1,1,0,1}, '{1,1,1,1,0}, '{1,1,1,0,1}, '{1,1,0,0,1},
            '{1,1,0,1,0}, '{1,1,1,0,1}, '{1,0,1,0,0}, '{1,1,0,1,0}, '{0,0,0,0,0},
            '{0,1,0,0,1}, '{1,0,0,1,0}};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) sh[k][i] = pat(i);
      for (int i = 0; i < 64; i++) ring[k][i].v = 0;
    end
    tick;
    men = 1;
    tick;
    tick;
    rst = 0;
    c_req = 1; c_we = 0; c_addr = 15'h10;
    @(negedge clk);
    chk("t1_c_gnt", c_gnt[0], 1);
    chk("t1_a_gnt", a_gnt[0], 0);
    chk("t1_mem_re", mre[0], 1);
    chk("t1_memaddr", ma[0], 15'h10);
    tick;
    c_req = 0;
    @(negedge clk);
    chk("t1_c_rvalid_early", c_rv[0], 0);
    tick;
    @(negedge clk);
    chk("t1_c_rvalid", c_rv[0], 1);
    chk("t1_c_rdata", c_rd[0], 16'hBEEF);
    chk("t1_a_rvalid", a_rv[0], 0);
    tick;
    a_req = 1; a_we = 1; a_addr = 15'h20; a_wdata = 16'h1234;
    @(negedge clk);
    chk("t2_a_gnt", a_gnt[0], 1);
    chk("t2_mem_we", mwe[0], 1);
    chk("t2_mem_re", mre[0], 0);
    chk("t2_wmemdata", wd[0], 16'h1234);
    tick;
    a_req = 0; a_we = 0; c_req = 1; c_we = 0; c_addr = 15'h20;
    @(negedge clk);
    chk("t2_c_gnt", c_gnt[0], 1);
    tick;
    c_req = 0;
    @(negedge clk);
    chk("t2_no_wr_c_rvalid", c_rv[0], 0);
    chk("t2_no_wr_a_rvalid", a_rv[0], 0);
    tick;
    @(negedge clk);
    chk("t2_c_rvalid", c_rv[0], 1);
    chk("t2_c_rdata", c_rd[0], 16'h1234);
    tick;
    c_req = 1; c_addr = 15'h3;
    @(negedge clk);
    chk("t3_c_gnt", c_gnt[0], 1);
    tick;
    c_req = 0; rst = 1;
    @(negedge clk);
    chk("t3_rst_gnt", c_gnt[0], 0);
    tick;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_c_rv0", c_rv[0], 0);
      chk("t3_c_rv1", c_rv[1], 0);
      tick;
    end
    c_req = 1; a_req = 1; c_we = 0; a_we = 0; a_lock = 0; c_addr = 15'h5; a_addr = 15'h6;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        tick;
        if (i == 4) begin c_req = 0; a_req = 0; end
      end
      @(negedge clk);
      if (i < 4) chk("t4_c_gnt", c_gnt[1], i % 2 == 0);
      chk("t4_c_rv1", c_rv[1], i >= 4 && i % 2 == 0);
      chk("t4_a_rv1", a_rv[1], i >= 4 && i % 2 == 1);
      chk("t4_c_rv0", c_rv[0], i >= 2 && i < 6 && i % 2 == 0);
      chk("t4_a_rv0", a_rv[0], i >= 2 && i < 6 && i % 2 == 1);
      if (i >= 4) chk("t4_rdata1", (i % 2 == 0) ? c_rd[1] : a_rd[1], (i % 2 == 0) ? pat(5) : pat(6));
    end
    tick;
    rst = 1;
    tick;
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      c_req = tbl[i].cr; a_req = tbl[i].ar; a_lock = tbl[i].al;
      c_addr = 15'(i); a_addr = 15'(i + 32);
      @(negedge clk);
      chk($sformatf("tbl%0d_c_gnt", i), c_gnt[0], tbl[i].ec);
      chk($sformatf("tbl%0d_a_gnt", i), a_gnt[0], tbl[i].ea);
      tick;
    end
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      c_req = 1'($urandom_range(0, 1));
      c_we = ($urandom_range(0, 3) == 0);
      c_addr = 15'($urandom_range(0, 31));
      c_wdata = 16'($urandom);
      a_req = ($urandom_range(0, 3) != 0);
      a_we = ($urandom_range(0, 3) == 0);
      a_addr = 15'($urandom_range(0, 31));
      a_wdata = 16'($urandom);
      a_lock = ($urandom_range(0, 3) != 0);
      tick;
    end
    rst = 0; c_req = 0; a_req = 0;
    repeat (6) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
